blink_period_monitor: RTL and testbench
=======================================

# blink_period_monitor

Downstream checker for the single-bit toggling output produced by the counter/toggle stage (its output `n2`).
- Measures the number of clock cycles between successive transitions of that signal and compares each measured period against an expected window.
- Counts out-of-window periods and flags a stalled signal, so a frozen or re-timed toggle output is visible at the top level.
- Runs on the same clock as the upstream stage; no synchronizer is required.

## Interface
Parameters:
- `CW`, 32: width of the period counter and the period outputs.
- `EXP_PERIOD`, 16: expected cycles between consecutive transitions.
- `TOL`, 1: allowed deviation. A period passes if `EXP_PERIOD-TOL <= period <= EXP_PERIOD+TOL`.
- `STALL_LIMIT`, 64: number of edge-free cycles before a stall is declared. Must satisfy `STALL_LIMIT > EXP_PERIOD+TOL` and `STALL_LIMIT < 2^CW-1`.

Ports:
- `n0` input 1: clock; all logic is on the rising edge.
- `n1` input 1: reset; synchronous, active-high.
- `sig_i` input 1: monitored toggle signal (upstream `n2`).
- `clr_i` input 1: synchronous clear of the statistics counters.
- `period_o` output CW: last measured period.
- `period_vld_o` output 1: one-cycle pulse when `period_o` updates.
- `err_o` output 1: one-cycle pulse when the measured period is out of window.
- `err_cnt_o` output 8: out-of-window count; saturates at 255.
- `edge_cnt_o` output 16: number of transitions seen; wraps.
- `stall_o` output 1: high while in state STALLED.
- `min_period_o` output CW: smallest checked period. Only meaningful with the option in Configuration.
- `max_period_o` output CW: largest checked period. Only meaningful with the option in Configuration.

## Operation
- **Edge detection.** `sig_q` is a register of `sig_i`. `edge = sig_i ^ sig_q`, evaluated combinationally in the current cycle. Both rising and falling transitions count.
- **Period counter.** `cnt` is cleared to 0 on a cycle with `edge`. Otherwise it increments, saturating at `2^CW-1`. The measured period is `cnt+1`.
- **State WAIT_FIRST** (reset state):
  - `cnt` holds at 0.
  - On `edge`: go to TRACK, clear `cnt`, increment `edge_cnt`. No period is reported.
- **State TRACK:**
  - On `edge`: `period_o <= cnt+1`, `period_vld_o` pulses, `edge_cnt` increments.
  - If the period is outside the window, `err_o` pulses and `err_cnt` increments, saturating at 255.
  - Without an edge, when `cnt == STALL_LIMIT-1`: go to STALLED, with `cnt` at `STALL_LIMIT`.
- **State STALLED:**
  - `stall_o` = 1 and `cnt` holds.
  - On `edge`: go to TRACK, clear `cnt`, increment `edge_cnt`. No period is reported and no check is made.
- **Simultaneous events:**
  - If `edge` coincides with the stall threshold, the edge wins and the FSM stays in TRACK.
  - If `clr_i` coincides with an error, `err_cnt_o` ends at 0; `err_o` still pulses.
  - `clr_i` zeroes `err_cnt`, `edge_cnt`, min and max. It does not affect the FSM, `cnt`, `sig_q` or `period_o`.
- **Reset mid-operation** returns everything to its reset value on the next clock edge, regardless of state.
- **Reset values:** every output is 0; the FSM is in WAIT_FIRST; `cnt` = 0; `sig_q` = 0. If `sig_i` = 1 in the first cycle after reset, that counts as the first edge.

## Timing
- Edge-detect cycle is T. At T+1, `period_o`, `period_vld_o`, `err_o`, `err_cnt_o` and `edge_cnt_o` show the result. Latency is 1 cycle.
- `period_vld_o` and `err_o` are high for exactly one cycle per checked edge.
- `stall_o` rises at the clock edge where `cnt` reaches `STALL_LIMIT`, i.e. `STALL_LIMIT` cycles after the last edge.
- `stall_o` falls one cycle after the recovering edge.
- The minimum supported transition spacing is 1 cycle, i.e. `sig_i` toggling every cycle gives period 1.

## Configuration
- `BLINK_PERIOD_MON_HIST_EN` defined:
  - `min_period_o` and `max_period_o` track the extremes of every checked period, updated in the same cycle as `period_o`.
  - The first checked period after reset or `clr_i` loads both registers.
- Not defined:
  - Both outputs are constant 0 and no min/max registers are synthesized.

## Test plan
- Reset, then toggle `sig_i` every 16 cycles for 10 transitions. Expect:
  - `edge_cnt_o`=10.
  - 9 `period_vld_o` pulses, each with `period_o`=16.
  - `err_o` never pulses; `err_cnt_o`=0.
  - With the macro defined, min=max=16.
- Toggle with spacings 16, 15, 17, 14, 18. Expect:
  - `err_o` on the 14 and 18 periods only.
  - `err_cnt_o`=2.
  - min=14, max=18 with the macro defined.
- Toggle once, then hold `sig_i` for 100 cycles. Expect:
  - `stall_o`=1 from 64 cycles after the edge.
  - The next edge gives no `period_vld_o`, and `stall_o`=0 one cycle later.
- Force 300 out-of-window periods. Expect:
  - `err_cnt_o` holds at 255.
  - Pulse `clr_i` on the same cycle as an error: `err_cnt_o`=0 afterward while `err_o` still pulses.
- Assert `n1` for one cycle while in TRACK with `err_cnt_o`=3. Expect:
  - All outputs read 0 on the next cycle and the FSM is in WAIT_FIRST.
  - The first post-reset edge reports no period.

Source files
------------

// File: rtl/blink_period_monitor_if.sv
// Signal bundle between the toggle source side and blink_period_monitor.
//   master : drives sig_i / clr_i, observes the monitor results
//   slave  : the monitor itself
// Signals:
//   sig_i        monitored toggle signal
//   clr_i        synchronous clear of the statistics counters
//   period_o     last measured period (CW bits)
//   period_vld_o one-cycle pulse when period_o updates
//   err_o        one-cycle pulse on an out-of-window period
//   err_cnt_o    saturating out-of-window count
//   edge_cnt_o   wrapping transition count
//   stall_o      high while the monitored signal is considered stalled
//   min_period_o smallest checked period (history option only)
//   max_period_o largest checked period (history option only)
interface blink_period_monitor_if #(
  parameter int unsigned CW = 32
);
  logic          sig_i;
  logic          clr_i;
  logic [CW-1:0] period_o;
  logic          period_vld_o;
  logic          err_o;
  logic [7:0]    err_cnt_o;
  logic [15:0]   edge_cnt_o;
  logic          stall_o;
  logic [CW-1:0] min_period_o;
  logic [CW-1:0] max_period_o;

  modport master (
    output sig_i, clr_i,
    input  period_o, period_vld_o, err_o, err_cnt_o, edge_cnt_o, stall_o,
    input  min_period_o, max_period_o
  );

  modport slave (
    input  sig_i, clr_i,
    output period_o, period_vld_o, err_o, err_cnt_o, edge_cnt_o, stall_o,
    output min_period_o, max_period_o
  );
endinterface

// File: rtl/blink_period_monitor.sv
// blink_period_monitor: measures the cycle spacing between successive
// transitions of a single-bit toggle signal, checks each period against
// EXP_PERIOD +/- TOL, counts violations and flags a stalled signal.
// Ports:
//   n0  clock, rising edge
//   n1  synchronous active-high reset
//   bus blink_period_monitor_if.slave (sig_i/clr_i in, results out)
// Option macro: BLINK_PERIOD_MON_HIST_EN enables min/max period tracking;
// without it min_period_o/max_period_o are tied to 0.
module blink_period_monitor #(
  parameter int unsigned CW          = 32,
  parameter int unsigned EXP_PERIOD  = 16,
  parameter int unsigned TOL         = 1,
  parameter int unsigned STALL_LIMIT = 64
) (
  input logic                   n0,
  input logic                   n1,
  blink_period_monitor_if.slave bus
);

  localparam logic [CW-1:0] LoBound    = CW'((EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0);
  localparam logic [CW-1:0] HiBound    = CW'(EXP_PERIOD + TOL);
  localparam logic [CW-1:0] StallLimM1 = CW'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {
    StWaitFirst,
    StTrack,
    StStalled
  } state_e;

  state_e        state_q, state_d;
  logic          sig_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [15:0]   edge_cnt_q, edge_cnt_d;

  logic          edge_det;
  logic [CW-1:0] period_meas;
  logic          in_window;
  logic          check;

  assign edge_det = bus.sig_i ^ sig_q;

  // Saturating increment doubles as the measured period (cnt + 1).
  assign period_meas = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  assign in_window   = (period_meas >= LoBound) && (period_meas <= HiBound);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    check   = 1'b0;
    unique case (state_q)
      StWaitFirst: begin
        cnt_d = '0;
        if (edge_det) state_d = StTrack;
      end
      StTrack: begin
        // An edge on the stall-threshold cycle still counts as a valid period.
        if (edge_det) begin
          cnt_d = '0;
          check = 1'b1;
        end else begin
          cnt_d = period_meas;
          if (cnt_q == StallLimM1) state_d = StStalled;
        end
      end
      StStalled: begin
        if (edge_det) begin
          cnt_d   = '0;
          state_d = StTrack;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StWaitFirst;
      end
    endcase
  end

  always_comb begin
    period_d   = check ? period_meas : period_q;
    vld_d      = check;
    err_d      = check & ~in_window;
    err_cnt_d  = err_cnt_q;
    edge_cnt_d = edge_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    if (edge_det) edge_cnt_d = edge_cnt_q + 16'd1;
    // Clear wins over a coincident error or edge; err_o still pulses.
    if (bus.clr_i) begin
      err_cnt_d  = '0;
      edge_cnt_d = '0;
    end
  end

  always_ff @(posedge n0) begin
    if (n1) begin
      state_q    <= StWaitFirst;
      sig_q      <= 1'b0;
      cnt_q      <= '0;
      period_q   <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      edge_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sig_q      <= bus.sig_i;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

`ifdef BLINK_PERIOD_MON_HIST_EN
  logic [CW-1:0] min_q, min_d;
  logic [CW-1:0] max_q, max_d;
  logic          hist_vld_q, hist_vld_d;

  always_comb begin
    min_d      = min_q;
    max_d      = max_q;
    hist_vld_d = hist_vld_q;
    if (check) begin
      // First checked period after reset/clear loads both extremes.
      if (!hist_vld_q || (period_meas < min_q)) min_d = period_meas;
      if (!hist_vld_q || (period_meas > max_q)) max_d = period_meas;
      hist_vld_d = 1'b1;
    end
    if (bus.clr_i) begin
      min_d      = '0;
      max_d      = '0;
      hist_vld_d = 1'b0;
    end
  end

  always_ff @(posedge n0) begin
    if (n1) begin
      min_q      <= '0;
      max_q      <= '0;
      hist_vld_q <= 1'b0;
    end else begin
      min_q      <= min_d;
      max_q      <= max_d;
      hist_vld_q <= hist_vld_d;
    end
  end

  assign bus.min_period_o = min_q;
  assign bus.max_period_o = max_q;
`else
  assign bus.min_period_o = '0;
  assign bus.max_period_o = '0;
`endif

  assign bus.period_o     = period_q;
  assign bus.period_vld_o = vld_q;
  assign bus.err_o        = err_q;
  assign bus.err_cnt_o    = err_cnt_q;
  assign bus.edge_cnt_o   = edge_cnt_q;
  assign bus.stall_o      = (state_q == StStalled);

endmodule

// File: tb/tb_blink_period_monitor.sv
// Self-checking bench for blink_period_monitor. A timestamp-based reference
// model (cycle index of the last transition) predicts every output after each
// clock; directed phases follow the test plan, then a randomized phase.
module tb_blink_period_monitor;
  localparam int unsigned CW  = 32;
  localparam int unsigned EXP = 16;
  localparam int unsigned TOL = 1;
  localparam int unsigned SL  = 64;

  logic n0;
  logic n1;

  blink_period_monitor_if #(.CW(CW)) bus ();

  blink_period_monitor #(
    .CW         (CW),
    .EXP_PERIOD (EXP),
    .TOL        (TOL),
    .STALL_LIMIT(SL)
  ) dut (
    .n0 (n0),
    .n1 (n1),
    .bus(bus)
  );

  initial begin
    n0 = 1'b0;
    forever #5 n0 = ~n0;
  end

  int n_checks = 0;
  int n_err    = 0;
  int vld_seen = 0;
  int err_seen = 0;
  logic cur_sig = 1'b0;

  // Reference model state
  int  m_cyc = 0;
  bit  m_prev_sig;
  bit  m_have;
  int  m_last;
  int unsigned m_period;
  bit  m_vld, m_err;
  int  m_err_cnt, m_edge_cnt;
  int unsigned m_min, m_max;
  bit  m_hv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp_v);
    end
  endtask

  task automatic model_update(input bit s, input bit c, input bit r);
    int d;
    bit e;
    m_cyc++;
    if (r) begin
      m_prev_sig = 0; m_have = 0; m_last = 0; m_period = 0; m_vld = 0; m_err = 0;
      m_err_cnt = 0; m_edge_cnt = 0; m_min = 0; m_max = 0; m_hv = 0;
      return;
    end
    e = (s != m_prev_sig);
    m_prev_sig = s;
    m_vld = 0;
    m_err = 0;
    if (e) begin
      d = m_cyc - m_last;
      if (m_have && d <= int'(SL)) begin
        m_period = d;
        m_vld = 1;
        m_err = (d < int'(EXP - TOL)) || (d > int'(EXP + TOL));
        if (!m_hv || d < int'(m_min)) m_min = d;
        if (!m_hv || d > int'(m_max)) m_max = d;
        m_hv = 1;
      end
      m_have = 1;
      m_last = m_cyc;
      m_edge_cnt = (m_edge_cnt + 1) % 65536;
    end
    if (m_err && m_err_cnt < 255) m_err_cnt++;
    if (c) begin
      m_err_cnt = 0; m_edge_cnt = 0; m_min = 0; m_max = 0; m_hv = 0;
    end
  endtask

  task automatic step(input logic s, input logic c, input logic r);
    bit stall_exp;
    bus.sig_i = s;
    bus.clr_i = c;
    n1 = r;
    @(posedge n0);
    model_update(s, c, r);
    #1;
    stall_exp = m_have && ((m_cyc - m_last) >= int'(SL));
    chk("period", bus.period_o, m_period);
    chk("vld", 32'(bus.period_vld_o), 32'(m_vld));
    chk("err", 32'(bus.err_o), 32'(m_err));
    chk("err_cnt", 32'(bus.err_cnt_o), m_err_cnt);
    chk("edge_cnt", 32'(bus.edge_cnt_o), m_edge_cnt);
    chk("stall", 32'(bus.stall_o), 32'(stall_exp));
`ifdef BLINK_PERIOD_MON_HIST_EN
    chk("min", bus.min_period_o, m_min);
    chk("max", bus.max_period_o, m_max);
`else
    chk("min", bus.min_period_o, 0);
    chk("max", bus.max_period_o, 0);
`endif
    if (bus.period_vld_o) vld_seen++;
    if (bus.err_o) err_seen++;
  endtask

  // Hold for k-1 cycles, then toggle on the k-th (spacing of k cycles).
  task automatic gap(input int k, input bit clr_last);
    for (int i = 0; i < k - 1; i++) step(cur_sig, 1'b0, 1'b0);
    cur_sig = ~cur_sig;
    step(cur_sig, clr_last, 1'b0);
  endtask

  initial begin
    int spacing[5] = '{16, 15, 17, 14, 18};
    int k;
    bus.sig_i = 1'b0;
    bus.clr_i = 1'b0;
    n1 = 1'b1;

    // Reset state
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_edge_cnt", 32'(bus.edge_cnt_o), 0);
    chk("rst_stall", 32'(bus.stall_o), 0);

    // Nominal period, 10 transitions
    vld_seen = 0; err_seen = 0;
    for (int i = 0; i < 10; i++) gap(16, 1'b0);
    chk("p1_edges", 32'(bus.edge_cnt_o), 10);
    chk("p1_vld_pulses", vld_seen, 9);
    chk("p1_err_pulses", err_seen, 0);

    // Window boundaries
    err_seen = 0;
    for (int i = 0; i < 5; i++) gap(spacing[i], 1'b0);
    chk("p2_err_pulses", err_seen, 2);
    chk("p2_err_cnt", 32'(bus.err_cnt_o), 2);

    // Stall detection and recovery
    gap(20, 1'b0);
    for (int i = 0; i < int'(SL) - 1; i++) step(cur_sig, 1'b0, 1'b0);
    chk("p3_stall_early", 32'(bus.stall_o), 0);
    step(cur_sig, 1'b0, 1'b0);
    chk("p3_stall_set", 32'(bus.stall_o), 1);
    for (int i = 0; i < 100 - int'(SL); i++) step(cur_sig, 1'b0, 1'b0);
    cur_sig = ~cur_sig;
    step(cur_sig, 1'b0, 1'b0);
    chk("p3_recover_vld", 32'(bus.period_vld_o), 0);
    chk("p3_recover_stall", 32'(bus.stall_o), 0);

    // Error counter saturation, then clear coinciding with an error
    for (int i = 0; i < 300; i++) gap(3, 1'b0);
    chk("p4_sat", 32'(bus.err_cnt_o), 255);
    gap(3, 1'b1);
    chk("p4_clr_err", 32'(bus.err_o), 1);
    chk("p4_clr_cnt", 32'(bus.err_cnt_o), 0);

    // Reset while tracking with err_cnt = 3
    cur_sig = 1'b0;
    step(cur_sig, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) gap(5, 1'b0);
    chk("p5_pre_err_cnt", 32'(bus.err_cnt_o), 3);
    step(cur_sig, 1'b0, 1'b1);
    chk("p5_rst_err_cnt", 32'(bus.err_cnt_o), 0);
    chk("p5_rst_period", bus.period_o, 0);
    gap(16, 1'b0);
    chk("p5_first_novld", 32'(bus.period_vld_o), 0);
    gap(16, 1'b0);
    chk("p5_second_period", bus.period_o, 16);
    for (int i = 0; i < 3; i++) gap(1, 1'b0);
    chk("p5_fast_period", bus.period_o, 1);

    // Randomized spacing, clear and reset
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1:    k = $urandom_range(1, 13);
        2, 3:    k = $urandom_range(19, 80);
        default: k = $urandom_range(14, 18);
      endcase
      for (int i = 0; i < k; i++) begin
        if (i == k - 1) cur_sig = ~cur_sig;
        step(cur_sig, ($urandom_range(0, 39) == 0), ($urandom_range(0, 799) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
